// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue sequencer and the ALU it drives:
// opcodes, instruction field layout and FSM state encoding.
package alu_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 13;
    localparam int INSTR_W  = 16;
    localparam int RA_W     = 3;
    localparam int OP_W     = 3;
    localparam int IMM_W    = 7;

    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RS_LSB  = 7;
    localparam int RT_LSB  = 4;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b010;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b100;
    localparam logic [OP_W-1:0] OP_SUBI = 3'b101;
    localparam logic [OP_W-1:0] OP_AND  = 3'b110;
    localparam logic [OP_W-1:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // rt and imm7 overlap in the encoding; both are extracted and the op picks one.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [RA_W-1:0]  rd;
        logic [RA_W-1:0]  rs;
        logic [RA_W-1:0]  rt;
        logic [IMM_W-1:0] imm;
    } fields_t;

    function automatic fields_t decode_fields(input logic [INSTR_W-1:0] word);
        fields_t f;
        f.op  = word[OP_LSB  +: OP_W];
        f.rd  = word[RD_LSB  +: RA_W];
        f.rs  = word[RS_LSB  +: RA_W];
        f.rt  = word[RT_LSB  +: RA_W];
        f.imm = word[IMM_LSB +: IMM_W];
        return f;
    endfunction

    function automatic logic uses_imm(input logic [OP_W-1:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x13 register file: two operand read ports, one debug read port, one
// synchronous write port, synchronous clear, and r0 hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = NUM_REGS,
    parameter int DW    = DATA_W,
    parameter int AW    = RA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem [NREGS];

    // NOTE: the array is cleared on reset so every register reads zero after
    // reset; this keeps the storage in flops, which is intended at this size.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // r0 is forced to zero on every read port regardless of storage contents.
    assign rdata_a  = (raddr_a  == '0) ? '0 : mem[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : mem[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Single-issue sequencer: accepts an instruction, reads operands, drives the
// external combinational ALU, captures its result and writes it back.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREGS = NUM_REGS,
    parameter int DW    = DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [OP_W-1:0]    alu_sel,
    input  logic [DW-1:0]      alu_result,
    output logic               done,
    output logic [RA_W-1:0]    wb_addr,
    output logic [DW-1:0]      wb_data,
    input  logic [RA_W-1:0]    dbg_addr,
    output logic [DW-1:0]      dbg_data
);

    state_t               state;
    state_t               next_state;
    logic [INSTR_W-1:0]   instr_q;
    fields_t              f;
    logic                 load_instr;
    logic                 load_ops;
    logic                 load_result;
    logic                 we;
    logic [DW-1:0]        rs_data;
    logic [DW-1:0]        rt_data;
    logic [DW-1:0]        imm_ext;

    assign f       = decode_fields(instr_q);
    assign imm_ext = {{(DW-IMM_W){1'b0}}, f.imm};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        load_instr  = 1'b0;
        load_ops    = 1'b0;
        load_result = 1'b0;
        done        = 1'b0;
        we          = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    load_instr = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                load_ops   = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                load_result = 1'b1;
                next_state  = ST_WB;
            end
            ST_WB: begin
                done       = 1'b1;
                we         = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        // A reset cycle never accepts a word nor reports a write-back.
        if (reset) begin
            instr_ready = 1'b0;
            done        = 1'b0;
            we          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            if (load_instr) begin
                instr_q <= instr;
            end
            if (load_ops) begin
                alu_a   <= rs_data;
                alu_b   <= uses_imm(f.op) ? imm_ext : rt_data;
                alu_sel <= f.op;
            end
            // wb_data doubles as the result register; it holds the ALU output through WB.
            if (load_result) begin
                wb_data <= alu_result;
                wb_addr <= f.rd;
            end
        end
    end

    alu_regfile #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (RA_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (wb_addr),
        .wdata    (wb_data),
        .raddr_a  (f.rs),
        .rdata_a  (rs_data),
        .raddr_b  (f.rt),
        .rdata_b  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
